// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiply sequencer with one or two writebacks and N/Z flags.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             long_op,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             wb_lo,
  output logic             wb_hi,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             flag_n,
  output logic             flag_z
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, CALC, FIX, WBLO, WBHI} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, fixed;
  logic [WIDTH-1:0]   ma_q, ma_d, a_mag, b_mag;
  logic               neg_q, neg_d, long_q, long_d, sgn, accept;
  logic [WIDTH:0]     sum;
  logic               busy_d, wb_lo_d, wb_hi_d, done_d, flag_n_d, flag_z_d;
  logic [WIDTH-1:0]   result_d;

  assign sgn    = signed_op & long_op;
  assign a_mag  = (sgn & a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn & b[WIDTH-1]) ? -b : b;
  assign accept = (state_q == IDLE) & start & ~cancel;
  assign sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, ma_q} : '0);
  assign fixed  = neg_q ? -prod_q : prod_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? CALC : IDLE;
      CALC:    state_d = (cnt_q == '0) ? FIX : CALC;
      FIX:     state_d = WBLO;
      WBLO:    state_d = long_q ? WBHI : IDLE;
      default: state_d = IDLE;
    endcase
    if (cancel) state_d = IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    ma_d   = ma_q;
    neg_d  = neg_q;
    long_d = long_q;
    if (accept) begin
      cnt_d  = CW'(WIDTH - 1);
      prod_d = {{WIDTH{1'b0}}, b_mag};
      ma_d   = a_mag;
      neg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      long_d = long_op;
    end else if (state_q == CALC) begin
      cnt_d  = cnt_q - 1'b1;
      prod_d = {sum, prod_q[WIDTH-1:1]};
    end else if (state_q == FIX) begin
      prod_d = fixed;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d   = state_d != IDLE;
    wb_lo_d  = state_d == WBLO;
    wb_hi_d  = state_d == WBHI;
    done_d   = (wb_lo_d & ~long_q) | wb_hi_d;
    result_d = wb_lo_d ? fixed[WIDTH-1:0] : wb_hi_d ? prod_q[2*WIDTH-1:WIDTH] : result;
    flag_n_d = wb_lo_d ? (long_q ? fixed[2*WIDTH-1] : fixed[WIDTH-1]) : flag_n;
    flag_z_d = wb_lo_d ? (long_q ? ~|fixed : ~|fixed[WIDTH-1:0]) : flag_z;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      prod_q <= '0;
      ma_q   <= '0;
      neg_q  <= 1'b0;
      long_q <= 1'b0;
      busy   <= 1'b0;
      wb_lo  <= 1'b0;
      wb_hi  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      ma_q   <= ma_d;
      neg_q  <= neg_d;
      long_q <= long_d;
      busy   <= busy_d;
      wb_lo  <= wb_lo_d;
      wb_hi  <= wb_hi_d;
      done   <= done_d;
      result <= result_d;
      flag_n <= flag_n_d;
      flag_z <= flag_z_d;
    end
  end
endmodule
